// File: rtl/wb_ip_hub_pkg.sv
// Shared types and constants for the Wishbone IP hub: FSM states, CSR map,
// identification and error response words, byte-lane merge helpers.
package wb_ip_hub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FWD,
      ST_RESP
   } state_t;

   localparam logic [7:0] CSR_ID      = 8'h00;
   localparam logic [7:0] CSR_IRQ_MSK = 8'h04;
   localparam logic [7:0] CSR_IRQ_PND = 8'h08;
   localparam logic [7:0] CSR_IO_SEL  = 8'h0C;
   localparam logic [7:0] CSR_STATUS  = 8'h10;

   localparam logic [31:0] ID_WORD     = 32'h4950_0000;
   localparam logic [31:0] ERR_DECODE  = 32'hBADA_DD00;
   localparam logic [31:0] ERR_TIMEOUT = 32'hDEAD_BEEF;

   function automatic logic [31:0] byte_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
      return (old_val & ~byte_mask(sel)) | (new_val & byte_mask(sel));
   endfunction

endpackage

// File: rtl/wb_ip_hub_if.sv
// Management-side Wishbone port of the hub (Caravel wbs_* naming).
// master = management SoC, slave = hub.
interface wb_ip_hub_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/wb_ip_hub_irq.sv
// Interrupt aggregation: rising-edge detect, W1C pending bits, mask and fold
// onto IRQ_W lines. Pending updates 1 cycle after the edge, user_irq 1 later.
module wb_ip_hub_irq #(
   parameter int NUM_SLV = 4,
   parameter int IRQ_W   = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SLV-1:0] irq,
   input  logic [NUM_SLV-1:0] msk,
   input  logic [NUM_SLV-1:0] w1c,
   output logic [NUM_SLV-1:0] pnd,
   output logic [IRQ_W-1:0]   user_irq
);

   logic [NUM_SLV-1:0] irq_q;
   logic [NUM_SLV-1:0] act;
   logic [IRQ_W-1:0]   fold;

   assign act = pnd & msk;

   // channel k drives line k mod IRQ_W
   always_comb begin
      fold = '0;
      for (int j = 0; j < IRQ_W; j++) begin
         for (int k = 0; k < NUM_SLV; k++) begin
            if ((k % IRQ_W) == j) fold[j] = fold[j] | act[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q    <= '0;
         pnd      <= '0;
         user_irq <= '0;
      end else begin
         irq_q    <= irq;
         // a new edge wins over a simultaneous clear
         pnd      <= (pnd & ~w1c) | (irq & ~irq_q);
         user_irq <= fold;
      end
   end

endmodule

// File: rtl/wb_ip_hub.sv
// Wishbone hub: decodes management cycles to NUM_SLV IP windows or the hub CSRs,
// forwards with timeout, aggregates IP interrupts and muxes the shared pads.
module wb_ip_hub
   import wb_ip_hub_pkg::*;
#(
   parameter int          NUM_SLV   = 4,
   parameter int          SLV_AW    = 8,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter int          IO_W      = 10,
   parameter int          IRQ_W     = 3,
   parameter int          TIMEOUT   = 255
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rstn_i,
   wb_ip_hub_if.slave                wbs,
   output logic [NUM_SLV-1:0]        m_cyc_o,
   output logic [NUM_SLV-1:0]        m_stb_o,
   output logic                      m_we_o,
   output logic [3:0]                m_sel_o,
   output logic [SLV_AW-1:0]         m_adr_o,
   output logic [31:0]               m_dat_o,
   input  logic [NUM_SLV-1:0]        m_ack_i,
   input  logic [NUM_SLV*32-1:0]     m_dat_i,
   input  logic [NUM_SLV-1:0]        irq_i,
   output logic [IRQ_W-1:0]          user_irq_o,
   input  logic [IO_W-1:0]           io_in_i,
   output logic [IO_W-1:0]           s_io_in_o,
   input  logic [NUM_SLV*IO_W-1:0]   s_io_out_i,
   input  logic [NUM_SLV*IO_W-1:0]   s_io_oeb_i,
   output logic [IO_W-1:0]           io_out_o,
   output logic [IO_W-1:0]           io_oeb_o
);

   localparam int IDXW = $clog2(NUM_SLV + 1);
   localparam int HB   = SLV_AW + IDXW;
   localparam int ISW  = IO_W * IDXW;
   localparam int TOW  = $clog2(TIMEOUT + 1);

   state_t              state_q;
   logic                ack_q;
   logic [31:0]         rdat_q;
   logic [IDXW-1:0]     idx_q;
   logic [TOW-1:0]      timer_q;
   logic [NUM_SLV-1:0]  msk_q;
   logic [ISW-1:0]      io_sel_q;
   logic                st_to_q;
   logic [2:0]          st_idx_q;

   logic [IDXW-1:0]     idx;
   logic [SLV_AW-1:0]   off;
   logic                hit;
   logic                req;
   logic                csr_wr;
   logic [31:0]         csr_rdata;
   logic [NUM_SLV-1:0]  pnd;
   logic [NUM_SLV-1:0]  pnd_w1c;
   logic                slv_ack;
   logic [31:0]         slv_dat;

   assign idx    = wbs.wbs_adr_i[SLV_AW +: IDXW];
   assign off    = wbs.wbs_adr_i[SLV_AW-1:0];
   assign hit    = (wbs.wbs_adr_i[31:HB] == BASE_ADDR[31:HB]);
   assign req    = (state_q == ST_IDLE) && wbs.wbs_cyc_i && wbs.wbs_stb_i;
   assign csr_wr = req && hit && (idx == IDXW'(NUM_SLV)) && wbs.wbs_we_i;

   assign pnd_w1c = (csr_wr && off == SLV_AW'(CSR_IRQ_PND))
                  ? NUM_SLV'(wbs.wbs_dat_i & byte_mask(wbs.wbs_sel_i)) : '0;

   assign wbs.wbs_ack_o = ack_q;
   assign wbs.wbs_dat_o = rdat_q;
   assign s_io_in_o     = io_in_i;

   // strobe is one-hot on the selected IP, so acks from other channels drop out
   assign slv_ack = |(m_ack_i & m_stb_o);

   always_comb begin
      slv_dat = '0;
      for (int k = 0; k < NUM_SLV; k++) begin
         if (idx_q == IDXW'(k)) slv_dat = m_dat_i[32*k +: 32];
      end
   end

   always_comb begin
      csr_rdata = '0;
      case (off)
         SLV_AW'(CSR_ID):      csr_rdata = ID_WORD | {24'h0, 8'(NUM_SLV)};
         SLV_AW'(CSR_IRQ_MSK): csr_rdata = 32'(msk_q);
         SLV_AW'(CSR_IRQ_PND): csr_rdata = 32'(pnd);
         SLV_AW'(CSR_IO_SEL):  csr_rdata = 32'(io_sel_q);
         SLV_AW'(CSR_STATUS):  csr_rdata = {21'h0, st_idx_q, 7'h0, st_to_q};
         default:              csr_rdata = '0;
      endcase
   end

   // pads whose selector names no IP fall back to input
   always_comb begin
      io_out_o = '0;
      io_oeb_o = '1;
      for (int p = 0; p < IO_W; p++) begin
         for (int k = 0; k < NUM_SLV; k++) begin
            if (io_sel_q[p*IDXW +: IDXW] == IDXW'(k)) begin
               io_out_o[p] = s_io_out_i[k*IO_W + p];
               io_oeb_o[p] = s_io_oeb_i[k*IO_W + p];
            end
         end
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         state_q  <= ST_IDLE;
         ack_q    <= 1'b0;
         rdat_q   <= '0;
         idx_q    <= '0;
         timer_q  <= '0;
         m_cyc_o  <= '0;
         m_stb_o  <= '0;
         m_we_o   <= 1'b0;
         m_sel_o  <= '0;
         m_adr_o  <= '0;
         m_dat_o  <= '0;
         msk_q    <= '0;
         io_sel_q <= '1;
         st_to_q  <= 1'b0;
         st_idx_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req) begin
                  if (hit && idx < IDXW'(NUM_SLV)) begin
                     state_q <= ST_FWD;
                     m_cyc_o <= NUM_SLV'(1) << idx;
                     m_stb_o <= NUM_SLV'(1) << idx;
                     m_we_o  <= wbs.wbs_we_i;
                     m_sel_o <= wbs.wbs_sel_i;
                     m_adr_o <= off;
                     m_dat_o <= wbs.wbs_dat_i;
                     idx_q   <= idx;
                     timer_q <= '0;
                  end else if (hit && idx == IDXW'(NUM_SLV)) begin
                     state_q <= ST_RESP;
                     ack_q   <= 1'b1;
                     rdat_q  <= csr_rdata;
                     if (wbs.wbs_we_i) begin
                        case (off)
                           SLV_AW'(CSR_IRQ_MSK):
                              msk_q <= NUM_SLV'(byte_merge(32'(msk_q), wbs.wbs_dat_i, wbs.wbs_sel_i));
                           SLV_AW'(CSR_IO_SEL):
                              io_sel_q <= ISW'(byte_merge(32'(io_sel_q), wbs.wbs_dat_i, wbs.wbs_sel_i));
                           SLV_AW'(CSR_STATUS):
                              if (wbs.wbs_sel_i[0] && wbs.wbs_dat_i[0]) st_to_q <= 1'b0;
                           default: ;
                        endcase
                     end
                  end else begin
                     state_q <= ST_RESP;
                     ack_q   <= 1'b1;
                     rdat_q  <= ERR_DECODE;
                  end
               end
            end
            ST_FWD: begin
               if (!wbs.wbs_cyc_i) begin
                  // master abandoned the cycle: release the IP without acking
                  state_q <= ST_IDLE;
                  m_cyc_o <= '0;
                  m_stb_o <= '0;
               end else if (slv_ack) begin
                  state_q <= ST_RESP;
                  ack_q   <= 1'b1;
                  rdat_q  <= slv_dat;
                  m_cyc_o <= '0;
                  m_stb_o <= '0;
               end else if (timer_q == TOW'(TIMEOUT)) begin
                  state_q  <= ST_RESP;
                  ack_q    <= 1'b1;
                  rdat_q   <= ERR_TIMEOUT;
                  m_cyc_o  <= '0;
                  m_stb_o  <= '0;
                  st_to_q  <= 1'b1;
                  st_idx_q <= 3'(idx_q);
               end else begin
                  timer_q <= timer_q + 1'b1;
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
               ack_q   <= 1'b0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   wb_ip_hub_irq #(
      .NUM_SLV (NUM_SLV),
      .IRQ_W   (IRQ_W)
   ) u_irq (
      .clk      (wb_clk_i),
      .rst_n    (wb_rstn_i),
      .irq      (irq_i),
      .msk      (msk_q),
      .w1c      (pnd_w1c),
      .pnd      (pnd),
      .user_irq (user_irq_o)
   );

endmodule

// File: tb/tb_wb_ip_hub.sv
// Directed bench for wb_ip_hub: scoreboarded WB transfers against IP models,
// CSR, interrupt, pad-mux, abort and asynchronous reset checks.
module tb_wb_ip_hub;

   localparam int NUM_SLV = 4;
   localparam int SLV_AW  = 8;
   localparam int IO_W    = 10;
   localparam int IRQ_W   = 3;
   localparam int TIMEOUT = 255;
   localparam int BUDGET  = 300;

   logic                    clk;
   logic                    rst_n;
   logic [NUM_SLV-1:0]      m_cyc_o, m_stb_o;
   logic                    m_we_o;
   logic [3:0]              m_sel_o;
   logic [SLV_AW-1:0]       m_adr_o;
   logic [31:0]             m_dat_o;
   logic [NUM_SLV-1:0]      m_ack_i;
   logic [NUM_SLV*32-1:0]   m_dat_i;
   logic [NUM_SLV-1:0]      irq_i;
   logic [IRQ_W-1:0]        user_irq_o;
   logic [IO_W-1:0]         io_in_i, s_io_in_o, io_out_o, io_oeb_o;
   logic [NUM_SLV*IO_W-1:0] s_io_out_i, s_io_oeb_i;

   wb_ip_hub_if wbs ();

   wb_ip_hub #(
      .NUM_SLV (NUM_SLV), .SLV_AW (SLV_AW), .BASE_ADDR (32'h3000_0000),
      .IO_W (IO_W), .IRQ_W (IRQ_W), .TIMEOUT (TIMEOUT)
   ) dut (
      .wb_clk_i   (clk),        .wb_rstn_i  (rst_n),     .wbs        (wbs),
      .m_cyc_o    (m_cyc_o),    .m_stb_o    (m_stb_o),   .m_we_o     (m_we_o),
      .m_sel_o    (m_sel_o),    .m_adr_o    (m_adr_o),   .m_dat_o    (m_dat_o),
      .m_ack_i    (m_ack_i),    .m_dat_i    (m_dat_i),   .irq_i      (irq_i),
      .user_irq_o (user_irq_o), .io_in_i    (io_in_i),   .s_io_in_o  (s_io_in_o),
      .s_io_out_i (s_io_out_i), .s_io_oeb_i (s_io_oeb_i),
      .io_out_o   (io_out_o),   .io_oeb_o   (io_oeb_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          ip_lat [NUM_SLV];
   logic [31:0] exp_dat_q [$];
   int          exp_lat_q [$];
   logic [NUM_SLV-1:0] snap_stb;
   logic [SLV_AW-1:0]  snap_adr;
   logic [31:0]        snap_dat;
   logic               snap_we;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // IP models: ack ip_lat[k] cycles after their strobe rises (0 = never ack)
   initial begin
      int cnt [NUM_SLV];
      m_ack_i = '0;
      for (int k = 0; k < NUM_SLV; k++) cnt[k] = 0;
      forever begin
         @(negedge clk);
         for (int k = 0; k < NUM_SLV; k++) begin
            if (m_ack_i[k]) begin
               m_ack_i[k] = 1'b0;
               cnt[k] = 0;
            end else if (m_stb_o[k] && ip_lat[k] != 0) begin
               cnt[k]++;
               if (cnt[k] == ip_lat[k]) m_ack_i[k] = 1'b1;
            end else begin
               cnt[k] = 0;
            end
         end
      end
   end

   task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd,
                       output int n, output bit got);
      @(negedge clk);
      wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = w;
      wbs.wbs_adr_i = a;    wbs.wbs_dat_i = d;    wbs.wbs_sel_i = s;
      n = 0; got = 1'b0; rd = '0;
      while (!got && n < BUDGET) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            snap_stb = m_stb_o; snap_adr = m_adr_o;
            snap_dat = m_dat_o; snap_we  = m_we_o;
         end
         if (wbs.wbs_ack_o) begin
            got = 1'b1;
            rd  = wbs.wbs_dat_o;
         end
      end
      wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
   endtask

   // latency counts negedges from strobe to ack: CSR=1, IP=lat+1, timeout=TIMEOUT+2
   task automatic sb_xfer(input string tag, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] s,
                          input logic [31:0] exp_d, input int exp_l);
      logic [31:0] rd, ed;
      int n, el;
      bit got;
      exp_dat_q.push_back(exp_d);
      exp_lat_q.push_back(exp_l);
      xfer(a, w, d, s, rd, n, got);
      ed = exp_dat_q.pop_front();
      el = exp_lat_q.pop_front();
      if (!got) chk({tag, "_ack_seen"}, 32'(got), 32'd1);
      else begin
         if (!w) chk({tag, "_dat"}, rd, ed);
         chk({tag, "_lat"}, 32'(n), 32'(el));
      end
   endtask

   initial begin
      int acks;
      rst_n = 1'b0;
      wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0; wbs.wbs_we_i = 1'b0;
      wbs.wbs_sel_i = '0;   wbs.wbs_adr_i = '0;   wbs.wbs_dat_i = '0;
      irq_i = '0;
      io_in_i = 10'h2A5;
      s_io_out_i = 40'h00_0000_0001;
      s_io_oeb_i = ~40'h00_0000_0400;
      m_dat_i = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h1234_5678};
      for (int k = 0; k < NUM_SLV; k++) ip_lat[k] = 1;

      repeat (3) @(negedge clk);
      chk("rst_ack", 32'(wbs.wbs_ack_o), 32'd0);
      chk("rst_dat", wbs.wbs_dat_o, 32'd0);
      chk("rst_mcyc", 32'(m_cyc_o), 32'd0);
      chk("rst_irq", 32'(user_irq_o), 32'd0);
      chk("rst_oeb", 32'(io_oeb_o), 32'h3FF);
      chk("io_in_bcast", 32'(s_io_in_o), 32'h2A5);
      rst_n = 1'b1;

      ip_lat[1] = 2;
      sb_xfer("ip1_wr", 32'h3000_0104, 1'b1, 32'h55, 4'hF, 32'h0, 3);
      chk("ip1_stb", 32'(snap_stb), 32'h2);
      chk("ip1_adr", 32'(snap_adr), 32'h04);
      chk("ip1_mdat", snap_dat, 32'h55);
      chk("ip1_we", 32'(snap_we), 32'd1);

      sb_xfer("csr_id", 32'h3000_0400, 1'b0, 32'h0, 4'hF, 32'h4950_0004, 1);
      sb_xfer("ip0_rd", 32'h3000_0010, 1'b0, 32'h0, 4'hF, 32'h1234_5678, 2);
      ip_lat[3] = 3;
      sb_xfer("ip3_rd", 32'h3000_0300, 1'b0, 32'h0, 4'hF, 32'h3333_3333, 4);
      sb_xfer("miss", 32'h4000_0000, 1'b0, 32'h0, 4'hF, 32'hBADA_DD00, 1);
      sb_xfer("idx5", 32'h3000_0500, 1'b1, 32'h1, 4'hF, 32'h0, 1);
      sb_xfer("idx5_rd", 32'h3000_0500, 1'b0, 32'h0, 4'hF, 32'hBADA_DD00, 1);

      ip_lat[2] = 0;
      sb_xfer("ip2_to", 32'h3000_0200, 1'b0, 32'h0, 4'hF, 32'hDEAD_BEEF, TIMEOUT + 2);
      sb_xfer("status", 32'h3000_0410, 1'b0, 32'h0, 4'hF, 32'h201, 1);
      sb_xfer("status_w1c", 32'h3000_0410, 1'b1, 32'h1, 4'hF, 32'h0, 1);
      sb_xfer("status_clr", 32'h3000_0410, 1'b0, 32'h0, 4'hF, 32'h200, 1);

      sb_xfer("msk_wr", 32'h3000_0404, 1'b1, 32'h8, 4'hF, 32'h0, 1);
      @(negedge clk); irq_i[3] = 1'b1;
      repeat (3) @(negedge clk);
      chk("uirq_b3", 32'(user_irq_o), 32'h1);
      sb_xfer("pnd_b3", 32'h3000_0408, 1'b0, 32'h0, 4'hF, 32'h8, 1);
      irq_i[3] = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk); #1; irq_i[3] = 1'b1;
      sb_xfer("pnd_w1c_race", 32'h3000_0408, 1'b1, 32'h8, 4'hF, 32'h0, 1);
      sb_xfer("pnd_kept", 32'h3000_0408, 1'b0, 32'h0, 4'hF, 32'h8, 1);
      irq_i[3] = 1'b0;
      sb_xfer("pnd_w1c", 32'h3000_0408, 1'b1, 32'h8, 4'hF, 32'h0, 1);
      sb_xfer("pnd_zero", 32'h3000_0408, 1'b0, 32'h0, 4'hF, 32'h0, 1);
      repeat (2) @(negedge clk);
      chk("uirq_clr", 32'(user_irq_o), 32'h0);
      sb_xfer("msk_wr2", 32'h3000_0404, 1'b1, 32'h2, 4'hF, 32'h0, 1);
      @(negedge clk); irq_i[1] = 1'b1;
      repeat (3) @(negedge clk);
      chk("uirq_b1", 32'(user_irq_o), 32'h2);

      sb_xfer("iosel_rst", 32'h3000_040C, 1'b0, 32'h0, 4'hF, 32'h3FFF_FFFF, 1);
      sb_xfer("iosel_b0", 32'h3000_040C, 1'b1, 32'h0, 4'h1, 32'h0, 1);
      sb_xfer("iosel_b0_rd", 32'h3000_040C, 1'b0, 32'h0, 4'hF, 32'h3FFF_FF00, 1);
      chk("pad_ip0_out", 32'(io_out_o), 32'h001);
      chk("pad_ip0_oeb", 32'(io_oeb_o), 32'h3FF);
      sb_xfer("iosel_p0", 32'h3000_040C, 1'b1, 32'h3FFF_FFF9, 4'hF, 32'h0, 1);
      @(negedge clk);
      chk("pad_ip1_out0", 32'(io_out_o), 32'h000);
      chk("pad_ip1_oeb", 32'(io_oeb_o), 32'h3FE);
      s_io_out_i[10] = 1'b1;
      #1;
      chk("pad_ip1_out1", 32'(io_out_o), 32'h001);

      ip_lat[3] = 0;
      @(negedge clk);
      wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1; wbs.wbs_we_i = 1'b0;
      wbs.wbs_adr_i = 32'h3000_0300; wbs.wbs_sel_i = 4'hF;
      repeat (3) @(negedge clk);
      chk("abort_stb", 32'(m_stb_o), 32'h8);
      wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0;
      @(negedge clk);
      chk("abort_mcyc", 32'(m_cyc_o), 32'h0);
      acks = 0;
      repeat (5) begin
         @(negedge clk);
         if (wbs.wbs_ack_o) acks++;
      end
      chk("abort_noack", 32'(acks), 32'd0);
      sb_xfer("post_abort", 32'h3000_0400, 1'b0, 32'h0, 4'hF, 32'h4950_0004, 1);

      @(negedge clk);
      wbs.wbs_cyc_i = 1'b1; wbs.wbs_stb_i = 1'b1;
      wbs.wbs_adr_i = 32'h3000_0300;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_mcyc", 32'(m_cyc_o), 32'h0);
      chk("arst_ack", 32'(wbs.wbs_ack_o), 32'h0);
      chk("arst_dat", wbs.wbs_dat_o, 32'h0);
      chk("arst_irq", 32'(user_irq_o), 32'h0);
      chk("arst_oeb", 32'(io_oeb_o), 32'h3FF);
      wbs.wbs_cyc_i = 1'b0; wbs.wbs_stb_i = 1'b0;
      irq_i = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sb_xfer("post_rst_msk", 32'h3000_0404, 1'b0, 32'h0, 4'hF, 32'h0, 1);
      sb_xfer("post_rst_sts", 32'h3000_0410, 1'b0, 32'h0, 4'hF, 32'h0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
